// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter
//   Shares the single GPR write port between the ALU and LSU writeback paths
//   using round-robin arbitration. It also keeps a per-register busy
//   scoreboard so issue logic can detect RAW hazards on rs1/rs2.
//
// Ports
//   clk, rst                    rising-edge clock, async active-high reset
//   alu_valid/ready/waddr/wdata ALU writeback handshake (ready = grant)
//   lsu_valid/ready/waddr/wdata LSU writeback handshake (ready = grant)
//   iss_valid, iss_waddr        destination register of the issuing instruction
//   rs1_addr, rs2_addr          hazard query addresses
//   rs1_busy, rs2_busy          combinational scoreboard lookups
//   busy_vec                    full scoreboard, bit i = xi pending
//   gpr_wen/waddr/wdata         registered GPR write port
module gpr_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [ADDR_WIDTH-1:0]      alu_waddr,
  input  logic [DATA_WIDTH-1:0]      alu_wdata,
  input  logic                       lsu_valid,
  output logic                       lsu_ready,
  input  logic [ADDR_WIDTH-1:0]      lsu_waddr,
  input  logic [DATA_WIDTH-1:0]      lsu_wdata,
  input  logic                       iss_valid,
  input  logic [ADDR_WIDTH-1:0]      iss_waddr,
  input  logic [ADDR_WIDTH-1:0]      rs1_addr,
  input  logic [ADDR_WIDTH-1:0]      rs2_addr,
  output logic                       rs1_busy,
  output logic                       rs2_busy,
  output logic [(1<<ADDR_WIDTH)-1:0] busy_vec,
  output logic                       gpr_wen,
  output logic [ADDR_WIDTH-1:0]      gpr_waddr,
  output logic [DATA_WIDTH-1:0]      gpr_wdata
);

  localparam int NREG = 1 << ADDR_WIDTH;

  // Round-robin pointer: which requester won the most recent transfer.
  typedef enum logic {
    RR_ALU = 1'b0,
    RR_LSU = 1'b1
  } rr_t;

  rr_t                   last_r;
  rr_t                   last_s;
  logic                  grant_alu_s;
  logic                  grant_lsu_s;
  logic                  xfer_s;
  logic [ADDR_WIDTH-1:0] sel_waddr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;
  logic [NREG-1:0]       busy_r;
  logic [NREG-1:0]       busy_s;

  // Grant: a lone requester wins; on a tie the one that did not win last time wins.
  always_comb begin
    grant_alu_s = 1'b0;
    grant_lsu_s = 1'b0;
    case ({alu_valid, lsu_valid})
      2'b10: grant_alu_s = 1'b1;
      2'b01: grant_lsu_s = 1'b1;
      2'b11: begin
        if (last_r == RR_LSU) begin
          grant_alu_s = 1'b1;
        end else begin
          grant_lsu_s = 1'b1;
        end
      end
      default: begin
        grant_alu_s = 1'b0;
        grant_lsu_s = 1'b0;
      end
    endcase
  end

  // Ready is the grant itself, so a transfer happens whenever either grant is high.
  assign alu_ready = grant_alu_s;
  assign lsu_ready = grant_lsu_s;
  assign xfer_s    = grant_alu_s | grant_lsu_s;

  // Next pointer and write-port source selection.
  always_comb begin
    last_s      = last_r;
    sel_waddr_s = alu_waddr;
    sel_wdata_s = alu_wdata;
    if (grant_lsu_s) begin
      last_s      = RR_LSU;
      sel_waddr_s = lsu_waddr;
      sel_wdata_s = lsu_wdata;
    end else if (grant_alu_s) begin
      last_s      = RR_ALU;
    end else begin
      last_s      = last_r;
    end
  end

  // Pointer register; resets to LSU so the ALU takes the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_r <= RR_LSU;
    end else begin
      last_r <= last_s;
    end
  end

  // Write-port register: x0 transfers are accepted but never raise gpr_wen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpr_wen   <= 1'b0;
      gpr_waddr <= '0;
      gpr_wdata <= '0;
    end else if (xfer_s) begin
      gpr_wen   <= (sel_waddr_s != {ADDR_WIDTH{1'b0}});
      gpr_waddr <= sel_waddr_s;
      gpr_wdata <= sel_wdata_s;
    end else begin
      gpr_wen   <= 1'b0;
    end
  end

  // Scoreboard next state: clear on the GPR commit edge, then set on issue so
  // a same-index set overrides the clear (a newer write is pending).
  always_comb begin
    busy_s = busy_r;
    if (gpr_wen) begin
      busy_s[gpr_waddr] = 1'b0;
    end else begin
      busy_s = busy_r;
    end
    if (iss_valid && (iss_waddr != {ADDR_WIDTH{1'b0}})) begin
      busy_s[iss_waddr] = 1'b1;
    end else begin
      busy_s[0] = 1'b0;
    end
    busy_s[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_s;
    end
  end

  assign busy_vec = busy_r;
  assign rs1_busy = busy_r[rs1_addr];
  assign rs2_busy = busy_r[rs2_addr];

endmodule
